// File: rtl/mem_access_unit_pkg.sv
// Shared types and encodings for the memory-stage access engine.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Byte-enable generation, store lane replication, load lane select/extension
// and illegal/misaligned access detection. Purely combinational.
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        illegal,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  sb;
        logic signed [31:0] sx;
        sb = b;
        sx = sb;
        return sgn ? sx : {24'b0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        sh = h;
        sx = sh;
        return sgn ? sx : {16'b0, h};
    endfunction

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        illegal   = 1'b0;
        misalign  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = ext_byte(byte_sel, funct3 == F3_B);
                illegal   = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = ext_half(half_sel, funct3 == F3_H);
                illegal   = is_store && (funct3 == F3_HU);
                misalign  = addr_lo[0];
            end
            F3_W: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: req/ack data bus FSM with timeout, stalling the
// pipeline until the access completes and registering the extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AluResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    state_t          state, state_nx;
    logic [TO_W-1:0] to_cnt;
    logic            access, is_load, illegal, misalign, bad, go, timeout;
    logic [31:0]     rdata_ext;

    // A store takes priority when both store and load are flagged.
    assign access    = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    assign is_load   = (ResultSrcM == RESULT_SRC_MEM) & ~MemWriteM;
    assign bad       = illegal | misalign;
    assign go        = access & ~bad;
    assign timeout   = ~dmem_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign dmem_addr = {AluResultM[31:2], 2'b00};

    load_store_align u_align (
        .is_store  (MemWriteM),
        .funct3    (funct3M),
        .addr_lo   (AluResultM[1:0]),
        .wdata     (WriteDataM),
        .rdata     (dmem_rdata),
        .be        (dmem_be),
        .wdata_rep (dmem_wdata),
        .rdata_ext (rdata_ext),
        .illegal   (illegal),
        .misalign  (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = BUSY;
            BUSY:    if (dmem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        StallM    = 1'b0;
        MisalignM = 1'b0;
        case (state)
            IDLE: begin
                StallM    = go;
                MisalignM = access & bad;
            end
            BUSY:    StallM = 1'b1;
            default: ;
        endcase
    end

    // Bus request, completion capture and timeout counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    dmem_req <= 1'b1;
                    dmem_we  <= MemWriteM;
                    to_cnt   <= '0;
                end
                BUSY: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    if (is_load) ReadDataM <= rdata_ext;
                end else if (timeout) begin
                    dmem_req  <= 1'b0;
                    dmem_we   <= 1'b0;
                    ReadDataM <= '0;
                    BusErrM   <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] AluResultM, WriteDataM, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, StallM, MisalignM, BusErrM;
    logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
    logic [3:0]  dmem_be;

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .ReadDataM(ReadDataM), .StallM(StallM),
        .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected outputs for the current cycle, written by the stimulus thread.
    logic        chk_en = 1'b0;
    logic        exp_req = 0, exp_we = 0, exp_stall = 0, exp_mis = 0, exp_berr = 0;
    logic [31:0] exp_rd = 0, exp_addr = 0, exp_wd = 0;
    logic [3:0]  exp_be = 0;
    logic        exp_bus_chk = 0;
    logic [31:0] rd_model = 0;

    int          stall_cnt, berr_cnt;
    logic        mis_seen;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd, obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic legal_f3(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1:0] == 2'd1) return a[0];
        if (f3[1:0] == 2'd2) return a != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
        if (f3[1:0] == 2'd0) return 4'(1 << int'(a));
        if (f3[1:0] == 2'd1) return 4'(3 << (int'(a) & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * int'(a))) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", {31'b0, dmem_req}, {31'b0, exp_req});
            chk("we", {31'b0, dmem_we}, {31'b0, exp_we});
            chk("stall", {31'b0, StallM}, {31'b0, exp_stall});
            chk("misalign", {31'b0, MisalignM}, {31'b0, exp_mis});
            chk("buserr", {31'b0, BusErrM}, {31'b0, exp_berr});
            chk("readdata", ReadDataM, exp_rd);
            if (exp_bus_chk) begin
                chk("be", {28'b0, dmem_be}, {28'b0, exp_be});
                chk("wdata", dmem_wdata, exp_wd);
                chk("addr", dmem_addr, exp_addr);
                obs_be   = dmem_be;
                obs_wd   = dmem_wdata;
                obs_addr = dmem_addr;
            end
            if (StallM) stall_cnt++;
            if (BusErrM) berr_cnt++;
            if (MisalignM) mis_seen = 1'b1;
        end
    end

    task automatic set_idle();
        MemWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        dmem_ack    = 1'b0;
        exp_req     = 0; exp_we = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0;
        exp_bus_chk = 0;
        exp_rd      = rd_model;
    endtask

    // One M-stage instruction; ack_at = BUSY cycle carrying the ack, 0 = never.
    task automatic txn(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at);
        logic access, good, berr;
        access = we | (rs == 2'b01);
        good   = access && legal_f3(we, f3) && !misaligned(f3, addr[1:0]);
        berr   = 1'b0;
        stall_cnt = 0; berr_cnt = 0; mis_seen = 1'b0;
        MemWriteM = we; ResultSrcM = rs; funct3M = f3;
        AluResultM = addr; WriteDataM = wd; dmem_rdata = rd;
        dmem_ack = 1'($urandom % 2);
        exp_req = 0; exp_we = 0; exp_stall = good; exp_mis = access && !good;
        exp_berr = 0; exp_rd = rd_model; exp_bus_chk = good;
        exp_be = m_be(f3, addr[1:0]); exp_wd = m_wd(f3, wd); exp_addr = addr & 32'hFFFF_FFFC;
        @(posedge clk); #1;
        if (good) begin
            for (int c = 1; c <= TO; c++) begin
                dmem_ack = (c == ack_at);
                exp_req = 1; exp_we = we; exp_stall = 1; exp_mis = 0;
                @(posedge clk); #1;
                if (c == ack_at) begin
                    if (!we) rd_model = m_ext(f3, addr[1:0], rd);
                    break;
                end
                if (c == TO) begin
                    rd_model = 0;
                    berr = 1'b1;
                end
            end
            dmem_ack = 1'($urandom % 2);
            exp_req = 0; exp_we = 0; exp_stall = 0; exp_berr = berr; exp_rd = rd_model;
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [2:0] legal_list [5];
        logic       we;
        logic [2:0] f3;
        int         ack_at;
        legal_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        funct3M = 3'd0; AluResultM = 0; WriteDataM = 0; dmem_rdata = 0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_rd", ReadDataM, 32'd0);
        chk("rst_berr", {31'b0, BusErrM}, 32'd0);
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Directed cases with hand-computed results.
        txn(1'b0, 2'b01, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_rd", ReadDataM, 32'hDEADBEEF);
        chk("lw_be", {28'b0, obs_be}, 32'hF);
        chk("lw_addr", obs_addr, 32'h100);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        txn(1'b0, 2'b01, 3'd0, 32'h103, 32'h0, 32'h80112233, 1);
        chk("lb_rd", ReadDataM, 32'hFFFFFF80);
        chk("lb_be", {28'b0, obs_be}, 32'b1000);
        txn(1'b0, 2'b01, 3'd4, 32'h103, 32'h0, 32'h80112233, 1);
        chk("lbu_rd", ReadDataM, 32'h00000080);
        txn(1'b1, 2'b00, 3'd1, 32'h202, 32'h0000ABCD, 32'h12345678, 3);
        chk("sh_be", {28'b0, obs_be}, 32'b1100);
        chk("sh_wdata", obs_wd, 32'hABCDABCD);
        chk("sh_rd_kept", ReadDataM, 32'h00000080);
        txn(1'b0, 2'b01, 3'd2, 32'h101, 32'h0, 32'h55555555, 1);
        chk("mis_seen", {31'b0, mis_seen}, 32'd1);
        chk("mis_stall", 32'(stall_cnt), 32'd0);
        txn(1'b0, 2'b01, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 0);
        chk("to_berr_pulses", 32'(berr_cnt), 32'd1);
        chk("to_rd", ReadDataM, 32'd0);
        chk("to_stall_cycles", 32'(stall_cnt), 32'(TO + 1));

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom % 2);
            f3 = ($urandom % 5 != 0) ? legal_list[$urandom % 5] : 3'($urandom);
            ack_at = ($urandom % 60 == 0) ? 0 : 1 + int'($urandom % 4);
            txn(we, 2'($urandom), f3, $urandom, $urandom, $urandom, ack_at);
        end

        // Prime ReadDataM, then reset in the middle of an access.
        txn(1'b0, 2'b01, 3'd2, 32'h44, 32'h0, 32'h0BADF00D, 1);
        MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'd2; AluResultM = 32'h40;
        dmem_ack = 1'b0;
        exp_stall = 1; exp_bus_chk = 1; exp_be = 4'hF; exp_addr = 32'h40;
        exp_wd = WriteDataM;
        @(posedge clk); #1;
        exp_req = 1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, dmem_req}, 32'd0);
        chk("midrst_we", {31'b0, dmem_we}, 32'd0);
        chk("midrst_rd", ReadDataM, 32'd0);
        chk("midrst_berr", {31'b0, BusErrM}, 32'd0);
        rd_model = 0;
        set_idle();
        #1;
        chk("midrst_stall", {31'b0, StallM}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        chk_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access engine; consumes the EX/MEM pipeline register outputs (AluResultM, WriteDataM, MemWriteM, ResultSrcM) plus funct3M.
- Drives a request/acknowledge data-memory bus and generates byte enables and store-data lane replication.
- Sign- or zero-extends load data and stalls the pipeline until the access completes.
- Its ReadDataM output feeds the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for dmem_ack before the access is aborted as a bus error
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
MemWriteM  in  1  store in M stage
ResultSrcM  in  2  2'b01 = load in M stage
funct3M  in  3  access size/sign (RV32I load/store encoding)
AluResultM  in  32  effective byte address
WriteDataM  in  32  store data, LSB-aligned
dmem_rdata  in  32  read word from memory
dmem_ack  in  1  memory accepted/completed current request
dmem_req  out  1  request valid, registered
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {AluResultM[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
ReadDataM  out  32  extended load result, registered
StallM  out  1  hold F/D/E/M pipeline registers
MisalignM  out  1  misaligned or illegal-funct3 access, no bus request issued
BusErrM  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dmem_req=0, dmem_we=0, ReadDataM=0, BusErrM=0, timeout counter=0. The same applies if reset is asserted mid-access: the request drops immediately and the access is lost.
- access = MemWriteM | (ResultSrcM==2'b01). If both are set, the store wins (dmem_we=1).
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misalign rules: halfword with addr[0]=1; word with addr[1:0]!=0.
- MisalignM is combinational: access & (illegal | misaligned), and is asserted only in IDLE. It never issues a request and never stalls.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE:
    - Legal access: go to BUSY, StallM=1, dmem_req<=1.
    - Otherwise: stay in IDLE, StallM=0.
  - BUSY: dmem_req=1 and StallM=1.
    - On dmem_ack: capture the extended rdata (loads only; stores leave ReadDataM unchanged) into ReadDataM, dmem_req<=0, go to DONE.
    - Counter reaches TIMEOUT_CYCLES without ack: dmem_req<=0, ReadDataM<=0, BusErrM<=1 for one cycle, go to DONE.
  - DONE: StallM=0, so the pipeline advances at this edge. Next state is IDLE.
- Minimum latency is 3 cycles (IDLE, BUSY with ack, DONE). Each extra wait cycle adds one.
- dmem_addr, dmem_be and dmem_wdata are combinational from the M-stage inputs. These inputs are stable while StallM=1.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
- Store data:
  - sb: {4{WriteDataM[7:0]}}.
  - sh: {2{WriteDataM[15:0]}}.
  - sw: WriteDataM.
- Load extension: select the lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- dmem_ack outside BUSY is ignored.
- The counter clears on entry to BUSY.

Decomposition:
- Shared package: FSM state enum (IDLE, BUSY, DONE); funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU); RESULT_SRC_MEM=2'b01.
- One combinational sub-module, load_store_align: computes the byte enables, store replication and load extension/lane select, plus illegal/misalign detection. The FSM and counter remain in the top module.

Test Plan:
- lw, addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111; StallM high 3 cycles; ReadDataM=0xDEADBEEF in DONE.
- lb, addr 0x103, rdata 0x80112233 -> be 1000; ReadDataM=0xFFFFFF80. The same with lbu -> 0x00000080.
- sh, addr 0x202, WriteDataM 0x0000ABCD -> dmem_we=1, be 1100, wdata 0xABCDABCD; ReadDataM unchanged.
- lw at addr 0x101 -> MisalignM=1, dmem_req never asserts, StallM=0.
- Load with no ack for TIMEOUT_CYCLES -> dmem_req drops, BusErrM single-cycle pulse, ReadDataM=0, StallM deasserts in DONE.
- rst_n pulled low while in BUSY -> dmem_req=0 immediately, state IDLE, ReadDataM=0; a late ack after reset release is ignored.
